reg_bank: RTL and testbench

32-entry × 32-bit general-purpose register file for the MIPS single-cycle datapath. It sits directly downstream of the 5-to-32 write-address decoder and consumes that decoder's one-hot write-select vector as per-register write enables. It provides two combinational read ports for the rs/rt operands. It also flags any malformed (multi-hot) select vector, so decoder or control faults are caught at the point of use.

---
 rtl/reg_bank_pkg.sv | 18 +
 rtl/reg_bank_cell.sv | 33 +++
 rtl/reg_bank.sv | 102 ++++++++++
 tb/tb_reg_bank.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: datapath-wide constants and types for the MIPS register file.
// Contents:
//   WIDTH, NREGS, SELECTOR : word width, register count, register-address width
//   reg_addr_t             : register-address type
//   word_t                 : data word type
//   REG_ZERO               : address of the hard-wired zero register
package reg_bank_pkg;

  localparam int WIDTH    = 32;
  localparam int NREGS    = 32;
  localparam int SELECTOR = 5;

  typedef logic [SELECTOR-1:0] reg_addr_t;
  typedef logic [WIDTH-1:0]    word_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_bank_cell.sv
// reg_cell: one storage word of the register file.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, clears the word
//   we_i   : write enable
//   d_i    : write data
//   q_o    : stored word
module reg_cell #(
  parameter int WIDTH = reg_bank_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (we_i) data_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_bank.sv
// reg_bank: 32 x 32 general-purpose register file fed by a one-hot write select.
// Register 0 is hard-wired to zero. A write select carrying two or more set
// bits while reg_write is high is rejected (nothing is written) and latches
// the sticky sel_error flag until reset.
// Optional feature: define REG_BYPASS_EN to forward write_data to a read port
// addressing the register being legally written in the same cycle.
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset (clears registers and sel_error)
//   reg_write  : write strobe
//   write_sel  : one-hot write select, bit i = register i, all-zero = register 0
//   write_data : write data
//   read_addr1 : port 1 address (rs)     read_data1 : port 1 data
//   read_addr2 : port 2 address (rt)     read_data2 : port 2 data
//   sel_error  : sticky multi-hot write-select flag
module reg_bank #(
  parameter int WIDTH    = reg_bank_pkg::WIDTH,
  parameter int NREGS    = reg_bank_pkg::NREGS,
  parameter int SELECTOR = reg_bank_pkg::SELECTOR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reg_write,
  input  logic [NREGS-1:0]    write_sel,
  input  logic [WIDTH-1:0]    write_data,
  input  logic [SELECTOR-1:0] read_addr1,
  input  logic [SELECTOR-1:0] read_addr2,
  output logic [WIDTH-1:0]    read_data1,
  output logic [WIDTH-1:0]    read_data2,
  output logic                sel_error
);

  import reg_bank_pkg::*;

  logic [WIDTH-1:0] regs [NREGS];
  logic             multi_hot;
  logic             seen_one;
  logic             legal_write;
  logic             illegal_write;
  logic             sel_error_q;
  logic             sel_error_d;

  // Popcount >= 2 detection without a full adder tree: remember whether a
  // set bit has already been seen; a second one marks the vector multi-hot.
  always_comb begin
    seen_one  = 1'b0;
    multi_hot = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (write_sel[i]) begin
        if (seen_one) multi_hot = 1'b1;
        seen_one = 1'b1;
      end
    end
  end

  assign legal_write   = reg_write & ~multi_hot;
  assign illegal_write = reg_write &  multi_hot;

  assign regs[0] = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_cell
    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk   (clk),
      .reset (reset),
      .we_i  (legal_write & write_sel[i]),
      .d_i   (write_data),
      .q_o   (regs[i])
    );
  end

  always_comb begin
    sel_error_d = sel_error_q;
    if (illegal_write) sel_error_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) sel_error_q <= 1'b0;
    else       sel_error_q <= sel_error_d;
  end

  assign sel_error = sel_error_q;

`ifdef REG_BYPASS_EN
  // A legal select is one-hot or zero, so write_sel[addr] alone identifies
  // the write target; address 0 is excluded so it keeps reading zero.
  always_comb begin
    read_data1 = regs[read_addr1];
    if (legal_write && (read_addr1 != REG_ZERO) && write_sel[read_addr1])
      read_data1 = write_data;
  end

  always_comb begin
    read_data2 = regs[read_addr2];
    if (legal_write && (read_addr2 != REG_ZERO) && write_sel[read_addr2])
      read_data2 = write_data;
  end
`else
  assign read_data1 = regs[read_addr1];
  assign read_data2 = regs[read_addr2];
`endif

endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [31:0] write_sel;
  logic [31:0] write_data;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        sel_error;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  reg_bank dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .write_sel  (write_sel),
    .write_data (write_data),
    .read_addr1 (read_addr1),
    .read_addr2 (read_addr2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .sel_error  (sel_error)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] sel;
    logic [31:0] data;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [31:0] sel,
                       input logic [31:0] data, input logic [4:0] a1, input logic [4:0] a2);
    reset      = rst;
    reg_write  = we;
    write_sel  = sel;
    write_data = data;
    read_addr1 = a1;
    read_addr2 = a2;
  endtask

  initial begin
    // rst, we, sel, data, a1, a2, exp1, exp2, exp_err  (outputs sampled after the edge)
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          5'd1,  5'd31, 32'h0,          32'h0,          1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF,  5'd9,  5'd8,  32'hDEAD_BEEF,  32'h0,          1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0002, 32'h1111_1111,  5'd1,  5'd9,  32'h1111_1111,  32'hDEAD_BEEF,  1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h2222_2222,  5'd2,  5'd1,  32'h2222_2222,  32'h1111_1111,  1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF,  5'd9,  5'd0,  32'hDEAD_BEEF,  32'h0,          1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF,  5'd1,  5'd0,  32'h1111_1111,  32'h0,          1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0000_0006, 32'h1234_5678,  5'd1,  5'd2,  32'h1111_1111,  32'h2222_2222,  1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0006, 32'h1234_5678,  5'd1,  5'd2,  32'h1111_1111,  32'h2222_2222,  1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,          5'd9,  5'd0,  32'hDEAD_BEEF,  32'h0,          1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001,  5'd31, 5'd9,  32'h0000_0001,  32'hDEAD_BEEF,  1'b1};
    vecs[10] = '{1'b0, 1'b1, 32'h8000_0000, 32'h0000_0002,  5'd31, 5'd2,  32'h0000_0002,  32'h2222_2222,  1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_5555,  5'd5,  5'd31, 32'h0000_5555,  32'h0000_0002,  1'b1};
    vecs[12] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0BAD_F00D,  5'd5,  5'd9,  32'h0,          32'h0,          1'b0};
    vecs[13] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,          5'd5,  5'd31, 32'h0,          32'h0,          1'b0};
    vecs[14] = '{1'b0, 1'b1, 32'h0000_0003, 32'hAAAA_AAAA,  5'd1,  5'd0,  32'h0,          32'h0,          1'b1};
    vecs[15] = '{1'b1, 1'b1, 32'h0000_0003, 32'hAAAA_AAAA,  5'd1,  5'd2,  32'h0,          32'h0,          1'b0};

    drive(1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    @(posedge clk);
    @(posedge clk);

    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      drive(vecs[v].rst, vecs[v].we, vecs[v].sel, vecs[v].data, vecs[v].a1, vecs[v].a2);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d rd1", v), read_data1, vecs[v].exp1);
      check($sformatf("vec%0d rd2", v), read_data2, vecs[v].exp2);
      check($sformatf("vec%0d sel_error", v), {31'b0, sel_error}, {31'b0, vecs[v].exp_err});
    end

    // Reset sweep: fill registers 1..31 with nonzero values, reset one cycle, read all.
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h1 << r, 32'h8000_0000 | (r * 32'h0101_0101), 5'(r), 5'(r));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd17, 5'd0);
    #1;
    check("prefill reg17", read_data1, 32'h8000_0000 | (32'd17 * 32'h0101_0101));
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    for (int r = 0; r < 32; r++) begin
      read_addr1 = 5'(r);
      read_addr2 = 5'(31 - r);
      #1;
      check($sformatf("sweep rd1 r%0d", r), read_data1, 32'h0);
      check($sformatf("sweep rd2 r%0d", 31 - r), read_data2, 32'h0);
    end
    check("sweep sel_error", {31'b0, sel_error}, 32'h0);

    // Multi-hot sticky: preload regs 1 and 2, illegal write, 10 idle cycles.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0000_0002, 32'h0000_00A1, 5'd1, 5'd2);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0000_0004, 32'h0000_00A2, 5'd1, 5'd2);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0000_0006, 32'h1234_5678, 5'd1, 5'd2);
    #1;
    check("mh err before edge", {31'b0, sel_error}, 32'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd1, 5'd2);
      #1;
      check($sformatf("mh err idle%0d", c), {31'b0, sel_error}, 32'h1);
    end
    check("mh reg1 kept", read_data1, 32'h0000_00A1);
    check("mh reg2 kept", read_data2, 32'h0000_00A2);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 5'd1, 5'd2);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd1, 5'd2);
    #1;
    check("mh err after reset", {31'b0, sel_error}, 32'h0);

    // Same-cycle read of the write target (register 31 holds 1).
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001, 5'd31, 5'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h8000_0000, 32'hA5A5_A5A5, 5'd31, 5'd31);
    #1;
`ifdef REG_BYPASS_EN
    check("same-cycle rd1", read_data1, 32'hA5A5_A5A5);
    check("same-cycle rd2", read_data2, 32'hA5A5_A5A5);
`else
    check("same-cycle rd1", read_data1, 32'h0000_0001);
    check("same-cycle rd2", read_data2, 32'h0000_0001);
`endif
    @(posedge clk);
    #1;
    check("post-edge rd1", read_data1, 32'hA5A5_A5A5);

    // Illegal write never forwards, and never changes the target.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h8000_0001 | 32'h0000_0100, 32'h5A5A_5A5A, 5'd31, 5'd8);
    #1;
    check("illegal no-fwd rd1", read_data1, 32'hA5A5_A5A5);
    check("illegal no-fwd rd2", read_data2, 32'h0);
    // Address 0 never forwards.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd31);
    #1;
    check("zero no-fwd rd1", read_data1, 32'h0);
    check("zero keeps reg31", read_data2, 32'hA5A5_A5A5);
    check("err after illegal", {31'b0, sel_error}, 32'h1);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
